// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and the multiply sequencer state encoding.
// Imported by the sequencer, its interface and the bench.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_SHL   = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_SHR   = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_ZERO  = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        DONE = 3'd4
    } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bundles the start/done handshake with the operand/result bus and the shared ALU connections.
// master = the sequencer; slave = the surrounding control unit plus the ALU.
interface alu_mul_sequencer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic                start;
    logic [WIDTH-1:0]    multiplicand;
    logic [WIDTH-1:0]    multiplier;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    product;
    logic                overflow;
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [WIDTH-1:0]    alu_out;
    logic                alu_zero;
    logic                alu_cout;

    modport master (
        input  start, multiplicand, multiplier, alu_out, alu_zero, alu_cout,
        output busy, done, product, overflow, alu_a, alu_b, alu_op
    );

    modport slave (
        output start, multiplicand, multiplier, alu_out, alu_zero, alu_cout,
        input  busy, done, product, overflow, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the shared 16-bit ALU for every add and shift,
// producing the low WIDTH bits of the unsigned product and a sticky overflow flag.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_mul_sequencer_if.master bus
);

    mul_state_e          state_q, state_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [WIDTH-1:0]    product_q, product_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    alu_a, alu_b;
    logic [ALU_OP_W-1:0] alu_op;

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = ALU_ZERO;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    mcand_d    = bus.multiplicand;
                    mplier_d   = bus.multiplier;
                    product_d  = '0;
                    overflow_d = 1'b0;
                    cnt_d      = '0;
                    if (bus.multiplier == '0)
                        state_d = DONE;
                    else if (bus.multiplier[0])
                        state_d = ADD;
                    else
                        state_d = SHL;
                end
            end
            ADD: begin
                alu_a      = product_q;
                alu_b      = mcand_q;
                alu_op     = ALU_ADD;
                product_d  = bus.alu_out;
                overflow_d = overflow_q | bus.alu_cout;
                state_d    = SHL;
            end
            SHL: begin
                alu_a    = mcand_q;
                alu_b    = WIDTH'(1);
                alu_op   = ALU_SHL;
                mcand_d  = bus.alu_out;
                // A bit shifted out of mcand still matters if a higher multiplier bit will add it.
                overflow_d = overflow_q | (mcand_q[WIDTH-1] & (mplier_q[WIDTH-1:1] != '0));
                state_d  = SHR;
            end
            SHR: begin
                alu_a    = mplier_q;
                alu_b    = WIDTH'(1);
                alu_op   = ALU_SHR;
                mplier_d = bus.alu_out;
                cnt_d    = cnt_q + CNT_W'(1);
                if (bus.alu_zero || (cnt_q == CNT_W'(WIDTH-1)))
                    state_d = DONE;
                else if (bus.alu_out[0])
                    state_d = ADD;
                else
                    state_d = SHL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q    <= '0;
            mplier_q   <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.busy     = (state_q == ADD) || (state_q == SHL) || (state_q == SHR);
    assign bus.done     = (state_q == DONE);
    assign bus.product  = product_q;
    assign bus.overflow = overflow_q;
    assign bus.alu_a    = alu_a;
    assign bus.alu_b    = alu_b;
    assign bus.alu_op   = alu_op;

endmodule
